// File: rtl/pe_modal.sv
// Systolic-array processing element with run-time selectable weight-stationary / output-stationary
// dataflow, double-buffered weights and saturating or wrapping accumulation.
module pe_modal #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int SATURATE   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pe_enabled,
  input  logic                  pe_mode,
  input  logic [ACC_WIDTH-1:0]  pe_psum_in,
  input  logic [DATA_WIDTH-1:0] pe_weight_in,
  input  logic                  pe_accept_w_in,
  input  logic [DATA_WIDTH-1:0] pe_input_in,
  input  logic                  pe_valid_in,
  input  logic                  pe_switch_in,
  input  logic                  pe_drain_in,
  output logic [ACC_WIDTH-1:0]  pe_psum_out,
  output logic                  pe_psum_valid_out,
  output logic [DATA_WIDTH-1:0] pe_weight_out,
  output logic                  pe_accept_w_out,
  output logic [DATA_WIDTH-1:0] pe_input_out,
  output logic                  pe_valid_out,
  output logic                  pe_switch_out,
  output logic                  pe_drain_out,
  output logic                  pe_overflow
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic {
    EMPTY  = 1'b0,
    LOADED = 1'b1
  } shadow_state_t;

  typedef struct packed {
    logic                 ovf;
    logic [ACC_WIDTH-1:0] sum;
  } add_t;

  shadow_state_t state, state_next;
  logic [DATA_WIDTH-1:0] w_active, w_active_next;
  logic [DATA_WIDTH-1:0] w_shadow, w_shadow_next;
  logic [ACC_WIDTH-1:0]  acc, acc_next;
  logic                  mode_prev;
  logic                  mode_change;

  logic signed [PROD_WIDTH-1:0] product_full;
  logic [ACC_WIDTH-1:0]         product;
  add_t                         ws_add, os_add;

  logic [ACC_WIDTH-1:0] psum_next;
  logic                 psum_valid_next;
  logic                 ovf_event;

  // One extra sign bit exposes signed overflow as a disagreement of the top two bits.
  function automatic add_t add_acc(input logic [ACC_WIDTH-1:0] a, input logic [ACC_WIDTH-1:0] b);
    logic [ACC_WIDTH:0] s;
    add_t               r;
    s     = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    r.ovf = s[ACC_WIDTH] ^ s[ACC_WIDTH-1];
    r.sum = s[ACC_WIDTH-1:0];
    if (r.ovf && (SATURATE != 0)) r.sum = s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    return r;
  endfunction

  assign product_full = PROD_WIDTH'($signed(pe_input_in)) * PROD_WIDTH'($signed(w_active));
  assign product      = ACC_WIDTH'(product_full);
  assign ws_add       = add_acc(pe_psum_in, product);
  assign os_add       = add_acc(acc, product);
  assign mode_change  = (pe_mode != mode_prev);

  // NOTE: every variable gets a default before any branch, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_next    = state;
    w_active_next = w_active;
    w_shadow_next = w_shadow;
    if (pe_accept_w_in && pe_switch_in) begin
      w_active_next = pe_weight_in;
      state_next    = EMPTY;
    end else if (pe_accept_w_in) begin
      w_shadow_next = pe_weight_in;
      state_next    = LOADED;
    end else if (pe_switch_in && (state == LOADED)) begin
      w_active_next = w_shadow;
      state_next    = EMPTY;
    end
  end

  always_comb begin
    acc_next        = acc;
    psum_next       = '0;
    psum_valid_next = 1'b0;
    ovf_event       = 1'b0;
    if (mode_change) acc_next = '0;
    if (!pe_mode) begin
      if (pe_valid_in) begin
        psum_next       = ws_add.sum;
        psum_valid_next = 1'b1;
        ovf_event       = ws_add.ovf;
      end
    end else if (!mode_change) begin
      if (pe_drain_in) begin
        psum_next       = acc;
        psum_valid_next = 1'b1;
        acc_next        = pe_valid_in ? product : '0;
      end else if (pe_valid_in) begin
        acc_next  = os_add.sum;
        ovf_event = os_add.ovf;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; this is what keeps the switch-cycle product on the old weight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      w_active <= '0;
      w_shadow <= '0;
    end else if (!pe_enabled) begin
      state    <= EMPTY;
      w_active <= '0;
      w_shadow <= '0;
    end else begin
      state    <= state_next;
      w_active <= w_active_next;
      w_shadow <= w_shadow_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc               <= '0;
      mode_prev         <= 1'b0;
      pe_psum_out       <= '0;
      pe_psum_valid_out <= 1'b0;
      pe_weight_out     <= '0;
      pe_accept_w_out   <= 1'b0;
      pe_input_out      <= '0;
      pe_valid_out      <= 1'b0;
      pe_switch_out     <= 1'b0;
      pe_drain_out      <= 1'b0;
      pe_overflow       <= 1'b0;
    end else if (!pe_enabled) begin
      acc               <= '0;
      mode_prev         <= 1'b0;
      pe_psum_out       <= '0;
      pe_psum_valid_out <= 1'b0;
      pe_weight_out     <= '0;
      pe_accept_w_out   <= 1'b0;
      pe_input_out      <= '0;
      pe_valid_out      <= 1'b0;
      pe_switch_out     <= 1'b0;
      pe_drain_out      <= 1'b0;
      pe_overflow       <= 1'b0;
    end else begin
      acc               <= acc_next;
      mode_prev         <= pe_mode;
      pe_psum_out       <= psum_next;
      pe_psum_valid_out <= psum_valid_next;
      pe_weight_out     <= pe_accept_w_in ? pe_weight_in : '0;
      pe_accept_w_out   <= pe_accept_w_in;
      if (pe_valid_in) pe_input_out <= pe_input_in;
      pe_valid_out      <= pe_valid_in;
      pe_switch_out     <= pe_switch_in;
      pe_drain_out      <= pe_drain_in;
      pe_overflow       <= pe_overflow | ovf_event;
    end
  end

endmodule

// File: tb/tb_pe_modal.sv
// Scoreboard bench for pe_modal: a saturating and a wrapping instance share stimulus and are
// compared against an integer reference model of the PE behaviour.
module tb_pe_modal;

  localparam int     DW   = 8;
  localparam int     AW   = 16;
  localparam longint HI   = 32767;
  localparam longint LO   = -32768;
  localparam longint SPAN = 65536;

  logic          clk;
  logic          rst_n;
  logic          pe_enabled, pe_mode, pe_accept_w_in, pe_valid_in, pe_switch_in, pe_drain_in;
  logic [AW-1:0] pe_psum_in;
  logic [DW-1:0] pe_weight_in, pe_input_in;

  logic [AW-1:0] s_psum_out, w_psum_out;
  logic [DW-1:0] s_weight_out, w_weight_out, s_input_out, w_input_out;
  logic s_psum_valid_out, s_accept_w_out, s_valid_out, s_switch_out, s_drain_out, s_overflow;
  logic w_psum_valid_out, w_accept_w_out, w_valid_out, w_switch_out, w_drain_out, w_overflow;

  pe_modal #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .pe_enabled(pe_enabled), .pe_mode(pe_mode),
    .pe_psum_in(pe_psum_in), .pe_weight_in(pe_weight_in), .pe_accept_w_in(pe_accept_w_in),
    .pe_input_in(pe_input_in), .pe_valid_in(pe_valid_in), .pe_switch_in(pe_switch_in),
    .pe_drain_in(pe_drain_in), .pe_psum_out(s_psum_out), .pe_psum_valid_out(s_psum_valid_out),
    .pe_weight_out(s_weight_out), .pe_accept_w_out(s_accept_w_out), .pe_input_out(s_input_out),
    .pe_valid_out(s_valid_out), .pe_switch_out(s_switch_out), .pe_drain_out(s_drain_out),
    .pe_overflow(s_overflow)
  );

  pe_modal #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .pe_enabled(pe_enabled), .pe_mode(pe_mode),
    .pe_psum_in(pe_psum_in), .pe_weight_in(pe_weight_in), .pe_accept_w_in(pe_accept_w_in),
    .pe_input_in(pe_input_in), .pe_valid_in(pe_valid_in), .pe_switch_in(pe_switch_in),
    .pe_drain_in(pe_drain_in), .pe_psum_out(w_psum_out), .pe_psum_valid_out(w_psum_valid_out),
    .pe_weight_out(w_weight_out), .pe_accept_w_out(w_accept_w_out), .pe_input_out(w_input_out),
    .pe_valid_out(w_valid_out), .pe_switch_out(w_switch_out), .pe_drain_out(w_drain_out),
    .pe_overflow(w_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [21:0] st_q_s[$], st_q_w[$];
  longint      ps_q_s[$], ps_q_w[$];

  // Reference model state: index 0 = saturating instance, 1 = wrapping instance.
  int          m_active, m_shadow;
  bit          m_loaded;
  longint      m_acc[2];
  bit          m_ovf[2];
  bit          m_mode_prev;
  logic [7:0]  m_in_fwd;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [21:0] pack(input logic v, input logic [7:0] inp, input logic [7:0] w,
                                       input logic aw, input logic sw, input logic dr,
                                       input logic ov, input logic pv);
    return {v, inp, w, aw, sw, dr, ov, pv};
  endfunction

  function automatic logic [21:0] status_s();
    return pack(s_valid_out, s_input_out, s_weight_out, s_accept_w_out, s_switch_out,
                s_drain_out, s_overflow, s_psum_valid_out);
  endfunction

  function automatic logic [21:0] status_w();
    return pack(w_valid_out, w_input_out, w_weight_out, w_accept_w_out, w_switch_out,
                w_drain_out, w_overflow, w_psum_valid_out);
  endfunction

  function automatic void add_ref(input longint a, input longint b, input bit sat,
                                  output longint r, output bit o);
    longint s;
    s = a + b;
    o = (s > HI) || (s < LO);
    if (!o)       r = s;
    else if (sat) r = (s > HI) ? HI : LO;
    else          r = (s > HI) ? s - SPAN : s + SPAN;
  endfunction

  function automatic void model_reset();
    m_active    = 0;
    m_shadow    = 0;
    m_loaded    = 1'b0;
    m_acc[0]    = 0;
    m_acc[1]    = 0;
    m_ovf[0]    = 1'b0;
    m_ovf[1]    = 1'b0;
    m_mode_prev = 1'b0;
    m_in_fwd    = '0;
  endfunction

  // Called at a falling edge: drives inputs, predicts the post-edge outputs, returns one cycle later.
  task automatic step(input bit en, input bit mode, input int psum_in, input int w, input bit aw,
                      input int in, input bit v, input bit sw, input bit dr);
    longint     prod, r;
    bit         o, pv;
    logic [7:0] wexp;
    pe_enabled     = en;
    pe_mode        = mode;
    pe_psum_in     = AW'(psum_in);
    pe_weight_in   = DW'(w);
    pe_accept_w_in = aw;
    pe_input_in    = DW'(in);
    pe_valid_in    = v;
    pe_switch_in   = sw;
    pe_drain_in    = dr;
    if (!en) begin
      model_reset();
      st_q_s.push_back('0);
      st_q_w.push_back('0);
    end else begin
      prod = longint'(in) * longint'(m_active);
      wexp = aw ? DW'(w) : 8'd0;
      if (v) m_in_fwd = DW'(in);
      for (int d = 0; d < 2; d++) begin
        pv = 1'b0;
        r  = 0;
        o  = 1'b0;
        if (mode != m_mode_prev) m_acc[d] = 0;
        if (!mode) begin
          if (v) begin
            add_ref(longint'(psum_in), prod, d == 0, r, o);
            m_ovf[d] = m_ovf[d] | o;
            pv = 1'b1;
          end
        end else if (mode == m_mode_prev) begin
          if (dr) begin
            pv = 1'b1;
            r  = m_acc[d];
            m_acc[d] = v ? prod : 0;
          end else if (v) begin
            add_ref(m_acc[d], prod, d == 0, r, o);
            m_acc[d] = r;
            m_ovf[d] = m_ovf[d] | o;
          end
        end
        if (d == 0) begin
          st_q_s.push_back(pack(v, m_in_fwd, wexp, aw, sw, dr, m_ovf[0], pv));
          if (pv) ps_q_s.push_back(r);
        end else begin
          st_q_w.push_back(pack(v, m_in_fwd, wexp, aw, sw, dr, m_ovf[1], pv));
          if (pv) ps_q_w.push_back(r);
        end
      end
      if (aw && sw) begin
        m_active = w;
        m_loaded = 1'b0;
      end else if (aw) begin
        m_shadow = w;
        m_loaded = 1'b1;
      end else if (sw && m_loaded) begin
        m_active = m_shadow;
        m_loaded = 1'b0;
      end
      m_mode_prev = mode;
    end
    @(negedge clk);
  endtask

  // Monitor: compares every registered output set and pops a result whenever a psum is presented.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (st_q_s.size() > 0) check("status_sat", longint'(status_s()), longint'(st_q_s.pop_front()));
        if (st_q_w.size() > 0) check("status_wrap", longint'(status_w()), longint'(st_q_w.pop_front()));
        if (s_psum_valid_out) begin
          if (ps_q_s.size() == 0) begin
            n_total++;
            $display("FAIL psum_sat_unexpected: got valid result %0d expected none", $signed(s_psum_out));
          end else check("psum_sat", longint'($signed(s_psum_out)), ps_q_s.pop_front());
        end
        if (w_psum_valid_out) begin
          if (ps_q_w.size() == 0) begin
            n_total++;
            $display("FAIL psum_wrap_unexpected: got valid result %0d expected none", $signed(w_psum_out));
          end else check("psum_wrap", longint'($signed(w_psum_out)), ps_q_w.pop_front());
        end
      end
    end
  end

  bit en_r, mode_r;

  initial begin
    rst_n = 1'b0; pe_enabled = 1'b1; pe_mode = 1'b0; pe_psum_in = '0; pe_weight_in = '0;
    pe_accept_w_in = 1'b0; pe_input_in = '0; pe_valid_in = 1'b0; pe_switch_in = 1'b0;
    pe_drain_in = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset_status", longint'(status_s()), 0);
    check("reset_psum", longint'(s_psum_out), 0);
    rst_n = 1'b1;

    // WS: load 3, swap in, -5*3 + 100
    step(1, 0, 0, 3, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 100, 0, 0, -5, 1, 0, 0);
    check("ws_psum", longint'($signed(s_psum_out)), 85);
    check("ws_psum_valid", longint'(s_psum_valid_out), 1);

    // switch in EMPTY keeps 3; simultaneous accept+switch takes 7 but this cycle still uses 3
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 1, 0, 0);
    check("empty_switch_keeps", longint'($signed(s_psum_out)), 3);
    step(1, 0, 0, 7, 1, 1, 1, 1, 0);
    check("switch_cycle_old_weight", longint'($signed(s_psum_out)), 3);
    step(1, 0, 0, 0, 0, 1, 1, 0, 0);
    check("direct_switch_new", longint'($signed(s_psum_out)), 7);

    // OS: 3 x 127*127 saturates / wraps
    step(1, 1, 0, 127, 1, 0, 0, 1, 0);
    repeat (3) step(1, 1, 0, 0, 0, 127, 1, 0, 0);
    check("os_ovf_sat", longint'(s_overflow), 1);
    check("os_ovf_wrap", longint'(w_overflow), 1);
    step(1, 1, 0, 0, 0, 0, 0, 0, 1);
    check("os_sat_acc", longint'($signed(s_psum_out)), 32767);
    check("os_wrap_acc", longint'($signed(w_psum_out)), -17149);
    check("os_drain_valid", longint'(s_psum_valid_out), 1);

    // OS: 2*4 + 2*4, drain with a new tile starting at 2*4
    step(1, 1, 0, 4, 1, 0, 0, 1, 0);
    repeat (2) step(1, 1, 0, 0, 0, 2, 1, 0, 0);
    step(1, 1, 0, 0, 0, 2, 1, 0, 1);
    check("os_drain", longint'($signed(s_psum_out)), 16);
    check("os_drain_valid2", longint'(s_psum_valid_out), 1);
    step(1, 1, 0, 0, 0, 0, 0, 0, 1);
    check("os_new_tile", longint'($signed(s_psum_out)), 8);

    // asynchronous reset in the middle of a tile
    repeat (2) step(1, 1, 0, 0, 0, 2, 1, 0, 0);
    check("pre_reset_ovf", longint'(s_overflow), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_status_sat", longint'(status_s()), 0);
    check("async_reset_status_wrap", longint'(status_w()), 0);
    check("async_reset_psum", longint'(s_psum_out), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 9, 0, 0, 5, 1, 0, 0);
    check("post_reset_active_zero", longint'($signed(s_psum_out)), 9);

    // WS overflow, then one disabled cycle wipes everything
    step(1, 0, 0, 2, 1, 0, 0, 1, 0);
    step(1, 0, 32767, 0, 0, 3, 1, 0, 0);
    check("ws_sat", longint'($signed(s_psum_out)), 32767);
    check("ws_wrap", longint'($signed(w_psum_out)), -32763);
    check("ws_ovf", longint'(s_overflow), 1);
    step(0, 0, 0, 9, 1, 4, 1, 1, 1);
    check("disable_status_sat", longint'(status_s()), 0);
    check("disable_status_wrap", longint'(status_w()), 0);
    check("disable_psum", longint'(s_psum_out), 0);
    step(1, 0, 0, 0, 0, 1, 1, 0, 0);
    check("disable_active_cleared", longint'($signed(s_psum_out)), 0);
    check("disable_then_valid", longint'(s_psum_valid_out), 1);

    // randomized traffic
    mode_r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      en_r = ($urandom_range(31) != 0);
      if ($urandom_range(15) == 0) mode_r = ~mode_r;
      step(en_r, mode_r, int'($urandom_range(65535)) - 32768, int'($urandom_range(255)) - 128,
           $urandom_range(3) == 0, int'($urandom_range(255)) - 128, $urandom_range(3) != 0,
           $urandom_range(4) == 0, $urandom_range(7) == 0);
    end
    step(1, mode_r, 0, 0, 0, 0, 0, 0, 0);

    check("psum_sat_drained", longint'(ps_q_s.size()), 0);
    check("psum_wrap_drained", longint'(ps_q_w.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pe_modal.md
PE_MODAL -- requirements
Module: pe_modal

Interface
REQ-001 Parameter DATA_WIDTH, default 8: signed two's-complement width of activations and weights.
REQ-002 Parameter ACC_WIDTH, default 32: signed width of partial sums and accumulator; SHALL be >= 2*DATA_WIDTH.
REQ-003 Parameter SATURATE, default 1: 1 = saturating accumulate, 0 = wrap-around accumulate.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 pe_enabled  in  1  0 = synchronous clear of all state at the next clock edge.
REQ-007 pe_mode  in  1  0 = weight-stationary (WS), 1 = output-stationary (OS).
REQ-008 pe_psum_in  in  ACC_WIDTH  north partial sum (WS only).
REQ-009 pe_weight_in / pe_accept_w_in  in  DATA_WIDTH / 1  north weight and its load strobe.
REQ-010 pe_input_in / pe_valid_in  in  DATA_WIDTH / 1  west activation and its valid.
REQ-011 pe_switch_in / pe_drain_in  in  1 / 1  west weight-swap and OS-drain strobes.
REQ-012 pe_psum_out / pe_psum_valid_out  out  ACC_WIDTH / 1  south result and its valid.
REQ-013 pe_weight_out / pe_accept_w_out  out  DATA_WIDTH / 1  south weight forward.
REQ-014 pe_input_out, pe_valid_out, pe_switch_out, pe_drain_out  out  DATA_WIDTH,1,1,1  east forwards.
REQ-015 pe_overflow  out  1  sticky saturation/wrap event flag.

Function
REQ-016 All outputs SHALL be registered; every forward (input, valid, switch, drain, weight, accept_w) SHALL have exactly 1-cycle latency.
REQ-017 pe_input_out SHALL update only when pe_valid_in=1, else hold; pe_weight_out SHALL equal pe_weight_in when pe_accept_w_in=1, else 0.
REQ-018 Product = signed pe_input_in * weight_active, full 2*DATA_WIDTH precision, sign-extended to ACC_WIDTH.
REQ-019 Shadow-weight FSM, states EMPTY/LOADED: accept_w -> LOADED (shadow <= pe_weight_in); switch in LOADED -> active <= shadow, EMPTY; switch with simultaneous accept_w -> active <= pe_weight_in directly, EMPTY; switch in EMPTY without accept_w -> active retained, state unchanged.
REQ-020 Product in the switch cycle SHALL use the pre-switch active weight.
REQ-021 WS mode: valid_in=1 -> pe_psum_out <= psum_in + product, pe_psum_valid_out=1; valid_in=0 -> pe_psum_out <= 0, pe_psum_valid_out=0.
REQ-022 OS mode: valid_in=1 and drain_in=0 -> acc <= acc + product; pe_psum_valid_out=0; pe_psum_in ignored.
REQ-023 OS mode drain_in=1: pe_psum_out <= acc, pe_psum_valid_out=1 for one cycle; acc <= product if valid_in=1 (new tile starts), else 0.
REQ-024 pe_mode change SHALL clear acc at the same edge; drain_in in WS mode SHALL only be forwarded east.
REQ-025 SATURATE=1: sum clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; SATURATE=0: sum wraps modulo 2^ACC_WIDTH; in both, signed overflow of any add SHALL set pe_overflow, held until reset or pe_enabled=0.

Reset
REQ-026 rst_n=0 SHALL asynchronously clear all outputs, acc, active and shadow weights to 0 and the shadow FSM to EMPTY, including mid-accumulation.
REQ-027 pe_enabled=0 SHALL produce the same cleared state synchronously at the next edge, overriding all other inputs.

Verification (DATA_WIDTH=8, ACC_WIDTH=16)
REQ-028 WS: load w=3, switch, valid input=-5, psum_in=100 -> next cycle psum_out=85, psum_valid_out=1.
REQ-029 Switch in EMPTY after prior w=3 -> active stays 3; accept_w=7 with switch same cycle -> active=7, next product uses 7.
REQ-030 OS, w=127: three valid inputs of 127, SATURATE=1 -> acc=32767 after third, pe_overflow=1; SATURATE=0 -> acc=-17149.
REQ-031 OS: accumulate 2*4+2*4=16, then drain with valid input 2 -> psum_out=16 with psum_valid_out=1, acc=8.
REQ-032 rst_n low mid-accumulation (acc=16, overflow=1) -> all outputs 0 immediately, next switch in EMPTY keeps active=0.
REQ-033 pe_enabled=0 for one cycle with accept_w=1, valid_in=1 -> all state 0 after the edge, no forward emitted.
